// File: rtl/algo_rdq_pkg.sv
// algo_rdq_pkg: shared helpers for the 1R1W read-request front end.
// Response entries are packed as {derr, serr, data}.
package algo_rdq_pkg;

  function automatic int rdq_ewid(input int width);
    return width + 2;
  endfunction

  function automatic int rdq_serr_pos(input int width);
    return width;
  endfunction

  function automatic int rdq_derr_pos(input int width);
    return width + 1;
  endfunction

  function automatic logic rdq_cred_ok(
    input int unsigned cred,
    input int unsigned depth
  );
    return cred < depth;
  endfunction

endpackage

// File: rtl/algo_1r1w_rdq_front_if.sv
// algo_1r1w_rdq_front_if: request and response valid/ready bundles.
// slave = front end side, master = requester/consumer side.
interface algo_1r1w_rdq_front_if #(
  parameter int WIDTH   = 64,
  parameter int BITADDR = 13
);
  logic               req_vld;
  logic               req_rdy;
  logic [BITADDR-1:0] req_adr;
  logic               rsp_vld;
  logic               rsp_rdy;
  logic [WIDTH-1:0]   rsp_data;
  logic               rsp_serr;
  logic               rsp_derr;

  modport master (
    output req_vld, req_adr, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_data, rsp_serr, rsp_derr
  );

  modport slave (
    input  req_vld, req_adr, rsp_rdy,
    output req_rdy, rsp_vld, rsp_data, rsp_serr, rsp_derr
  );
endinterface

// File: rtl/algo_rdq_fifo.sv
// algo_rdq_fifo: synchronous FIFO, registered storage, no bypass.
// Ports: push/din, pop, head (entry at read pointer), count (occupancy).
module algo_rdq_fifo #(
  parameter int DEPTH    = 4,
  parameter int BITDEPTH = 2,
  parameter int EWID     = 66
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [EWID-1:0]   din,
  input  logic              pop,
  output logic [EWID-1:0]   head,
  output logic [BITDEPTH:0] count
);
  localparam int PW = (BITDEPTH > 0) ? BITDEPTH : 1;
  localparam int CW = BITDEPTH + 1;

  logic [EWID-1:0] mem [DEPTH];
  logic [PW-1:0]   wp;
  logic [PW-1:0]   rp;
  logic            full;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = count == CW'(DEPTH);
  assign do_pop  = pop && (count != '0);
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rp];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= inc(wp);
      end
      if (do_pop) rp <= inc(rp);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/algo_1r1w_rdq_front.sv
// algo_1r1w_rdq_front: credit-based read front end for the 1R1W wrapper.
// Ports: bus (req/rsp handshakes), ready/read/rd_adr/rd_* to wrapper, err flags.
module algo_1r1w_rdq_front
  import algo_rdq_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int BITADDR   = 13,
  parameter int RD_LAT    = 2,
  parameter int FIFODEPTH = 4,
  parameter int BITFIFO   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  algo_1r1w_rdq_front_if.slave bus,
  input  logic                 ready,
  output logic                 read,
  output logic [BITADDR-1:0]   rd_adr,
  input  logic                 rd_vld,
  input  logic [WIDTH-1:0]     rd_dout,
  input  logic                 rd_serr,
  input  logic                 rd_derr,
  output logic                 err_unexp,
  output logic                 err_miss
);
  localparam int RDQ_EWID = rdq_ewid(WIDTH);
  localparam int SERR     = rdq_serr_pos(WIDTH);
  localparam int DERR     = rdq_derr_pos(WIDTH);
  localparam int CW       = BITFIFO + 1;

  logic [CW-1:0]       cred;
  logic [CW-1:0]       cred_nxt;
  logic [CW:0]         cred_up;
  logic [CW:0]         cred_dn;
  logic [CW-1:0]       cnt;
  logic [RD_LAT-1:0]   due;
  logic                due_now;
  logic                miss;
  logic                pop;
  logic [RDQ_EWID-1:0] din;
  logic [RDQ_EWID-1:0] head;

  // rst gates req_rdy so nothing is offered while held in reset.
  assign bus.req_rdy = rst && ready
                     && rdq_cred_ok(32'(cred), FIFODEPTH);
  assign read        = bus.req_vld && bus.req_rdy;
  assign rd_adr      = bus.req_adr;

  assign due_now = due[RD_LAT-1];
  assign miss    = due_now && !rd_vld;
  assign pop     = bus.rsp_vld && bus.rsp_rdy;
  assign din     = {rd_derr, rd_serr, rd_dout};

  assign bus.rsp_vld  = cnt != '0;
  assign bus.rsp_data = head[WIDTH-1:0];
  assign bus.rsp_serr = head[SERR];
  assign bus.rsp_derr = head[DERR];

  // Pops of unexpected (uncredited) entries would underflow; floor at 0.
  always_comb begin
    cred_up  = {1'b0, cred} + (CW + 1)'(read);
    cred_dn  = (CW + 1)'(pop) + (CW + 1)'(miss);
    cred_nxt = (cred_up < cred_dn) ? '0 : CW'(cred_up - cred_dn);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cred      <= '0;
      due       <= '0;
      err_unexp <= 1'b0;
      err_miss  <= 1'b0;
    end else begin
      cred <= cred_nxt;
      due  <= RD_LAT'({due, read});
      if (rd_vld && !due_now) err_unexp <= 1'b1;
      if (miss) err_miss <= 1'b1;
    end
  end

  algo_rdq_fifo #(
    .DEPTH    (FIFODEPTH),
    .BITDEPTH (BITFIFO),
    .EWID     (RDQ_EWID)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_vld),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .count (cnt)
  );
endmodule
